// File: rtl/cov_sequencer_if.sv
// Sequencer <-> ICA control / datapath bundle.
// master = sequencer side, slave = controller/datapath side.
interface cov_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              GO;
  logic              Div_done;
  logic              Sample_rd;
  logic [ADDR_W-1:0] Sample_addr;
  logic              Acc_clr;
  logic              En_Multi;
  logic              En_acc;
  logic              En_div;
  logic              Cov_busy;
  logic              Cov_done;
  logic              Cov_err;

  modport master (
    input  GO,
    input  Div_done,
    output Sample_rd,
    output Sample_addr,
    output Acc_clr,
    output En_Multi,
    output En_acc,
    output En_div,
    output Cov_busy,
    output Cov_done,
    output Cov_err
  );

  modport slave (
    output GO,
    output Div_done,
    input  Sample_rd,
    input  Sample_addr,
    input  Acc_clr,
    input  En_Multi,
    input  En_acc,
    input  En_div,
    input  Cov_busy,
    input  Cov_done,
    input  Cov_err
  );
endinterface

// File: rtl/cov_sequencer.sv
// Covariance run sequencer: clear, stream, drain, divide.
// All outputs are registered from the next state.
module cov_sequencer #(
  parameter int N_SAMPLES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input logic             CLK,
  input logic             RST,
  cov_sequencer_if.master bus
);
  localparam int TW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(DIV_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, DRAIN, DIVIDE, DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [TW-1:0]     tcnt, tcnt_d;
  logic [MUL_LAT:0]  dl;
  logic              rd, rd_d;
  logic              clr, clr_d;
  logic              div, div_d;
  logic              busy, busy_d;
  logic              done, done_d;
  logic              err, err_d;
  logic              pipe_empty;

  // Only the en_acc tap may still be set when DRAIN may leave.
  assign pipe_empty = (dl[MUL_LAT-1:0] == '0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.GO) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (addr == LAST) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DIVIDE;
      DIVIDE: begin
        if (bus.Div_done)     state_d = DONE;
        else if (tcnt == TMAX) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == STREAM);
    clr_d  = (state_d == CLEAR);
    div_d  = (state_d == DIVIDE) && (state != DIVIDE);
    done_d = (state_d == DONE);
    err_d  = (state == DIVIDE) && (state_d == IDLE);
    busy_d = (state_d == CLEAR) || (state_d == STREAM) ||
             (state_d == DRAIN) || (state_d == DIVIDE);

    addr_d = addr;
    if (state_d == CLEAR)
      addr_d = '0;
    else if (state == STREAM && state_d == STREAM)
      addr_d = addr + ADDR_W'(1);

    tcnt_d = '0;
    if (state == DIVIDE && state_d == DIVIDE)
      tcnt_d = tcnt + TW'(1);
  end

  // Output, counter and enable delay-line registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= '0;
      tcnt <= '0;
      dl   <= '0;
      rd   <= 1'b0;
      clr  <= 1'b0;
      div  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      addr <= addr_d;
      tcnt <= tcnt_d;
      dl   <= {dl[MUL_LAT-1:0], rd};
      rd   <= rd_d;
      clr  <= clr_d;
      div  <= div_d;
      busy <= busy_d;
      done <= done_d;
      err  <= err_d;
    end
  end

  assign bus.Sample_rd   = rd;
  assign bus.Sample_addr = addr;
  assign bus.Acc_clr     = clr;
  assign bus.En_Multi    = dl[0];
  assign bus.En_acc      = dl[MUL_LAT];
  assign bus.En_div      = div;
  assign bus.Cov_busy    = busy;
  assign bus.Cov_done    = done;
  assign bus.Cov_err     = err;
endmodule

// File: doc/cov_sequencer.md
# cov_sequencer

Synchronous sequencer for the whitening covariance datapath. On a start pulse it clears the accumulators and streams N_SAMPLES centred sample vectors from sample memory. It drives the multiplier and accumulator enables, aligned to their pipeline latencies, then triggers the final divide and waits for the divider to finish. It reports busy, done and timeout status back to the ICA top-level control.

## Interface
Parameters:
- N_SAMPLES, 1024, samples per covariance run; power of two, ≥1
- ADDR_W, 10, sample-memory address width; 2^ADDR_W ≥ N_SAMPLES
- MUL_LAT, 2, cycles from En_Multi to a valid product at the accumulator input; ≥1
- DIV_TIMEOUT, 64, maximum cycles to wait for Div_done after En_div

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- GO  in  1  start request; sampled only in IDLE
- Div_done  in  1  one-cycle pulse from the divider; counts only in DIVIDE
- Sample_rd  out  1  sample-memory read strobe; data is valid the next cycle
- Sample_addr  out  ADDR_W  sample-memory read address
- Acc_clr  out  1  clears all ten accumulators
- En_Multi  out  1  multiplier stage enable
- En_acc  out  1  accumulate-product enable
- En_div  out  1  one-cycle divide start
- Cov_busy  out  1  high while a run is in progress
- Cov_done  out  1  one-cycle pulse when C11..C44 are valid
- Cov_err  out  1  one-cycle pulse on divider timeout

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DIVIDE, DONE. All outputs are registered (Moore outputs).
- Transitions:
  - IDLE→CLEAR when GO=1.
  - CLEAR→STREAM unconditionally.
  - STREAM→DRAIN after the read at address N_SAMPLES-1.
  - DRAIN→DIVIDE when the enable delay line is empty.
  - DIVIDE→DONE on Div_done.
  - DIVIDE→IDLE on timeout.
  - DONE→IDLE unconditionally.
- Read address counter: ADDR_W bits, reset to 0 on entry to CLEAR, increments on each Sample_rd, and never wraps within a run.
- En_Multi is Sample_rd delayed 1 cycle, matching memory latency.
- En_acc is En_Multi delayed MUL_LAT cycles, through a shift register that is cleared on RST.
- DRAIN exits in the cycle after the last En_acc.
- Timeout counter: counts cycles spent in DIVIDE, starting at 0 on entry. When it reaches DIV_TIMEOUT without Div_done, the FSM pulses Cov_err, does not pulse Cov_done, and returns to IDLE.
- Ignored inputs: GO outside IDLE, and Div_done outside DIVIDE.
- Div_done arriving in the same cycle the timeout is reached: Div_done wins and the run completes normally.
- GO held high continuously: a new run starts in the cycle after DONE, i.e. on the first IDLE cycle.
- RST at any time, including mid-run: in the next cycle the FSM is in IDLE, the counters and delay line are zero, and every output is 0.
- No arithmetic in this block. The divider divides by N_SAMPLES, which is a constant shift of log2(N_SAMPLES).

## Timing
- Reset values: every output is 0; Sample_addr is 0.
- Cycle references: cycle 0 is the IDLE cycle in which GO=1 is sampled.
- Cycle 1, CLEAR:
  - Acc_clr=1.
  - Cov_busy rises and stays high through the last DIVIDE cycle.
- Cycles 2 … N+1, STREAM: Sample_rd=1 and Sample_addr=cycle−2.
- Cycles 3 … N+2: En_Multi=1.
- Cycles 3+MUL_LAT … N+2+MUL_LAT: En_acc=1.
- Cycle N+3+MUL_LAT: first DIVIDE cycle, with En_div=1 for this one cycle only.
- Div_done seen in cycle k:
  - DONE in cycle k+1, with Cov_done=1 and Cov_busy=0.
  - IDLE in cycle k+2.
- Timeout: Cov_err=1 in the cycle after the DIVIDE count reaches DIV_TIMEOUT. Cov_busy=0 in that cycle, and IDLE follows.
- Minimum run length (Div_done in the first DIVIDE cycle): N+5+MUL_LAT cycles from GO to returning to IDLE.

## Test plan
- Nominal run, N_SAMPLES=4, MUL_LAT=2, GO at cycle 0, Div_done at cycle 12. Required response:
  - Acc_clr @1.
  - Sample_addr 0,1,2,3 @2..5.
  - En_Multi @3..6 and En_acc @5..8.
  - En_div @9.
  - Cov_done @13, and Cov_busy high @1..12.
- GO pulses at cycles 4 and 9 during that run: both ignored, with no second Acc_clr and the address sequence unchanged. GO held high through cycle 14: next Acc_clr @15.
- Divider timeout, DIV_TIMEOUT=8, Div_done never asserted: Cov_err pulses once, Cov_done never pulses, FSM returns to IDLE, and a later GO runs normally.
- Simultaneous events: Div_done arriving on the cycle the timeout is reached gives Cov_done=1 and Cov_err=0. A stray Div_done in STREAM has no effect.
- Reset mid-STREAM, RST=1 at Sample_addr=2: next cycle all outputs are 0. A fresh GO then restarts from address 0 with a single Acc_clr.
- N_SAMPLES=1, MUL_LAT=1: Sample_rd @2, En_Multi @3, En_acc @4, En_div @5.
